// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
// Pattern generator uses x^19+x^5+x^2+x+1; signature compactor uses x^10+x^3+1.
package gate_bist_pkg;

    localparam int IN_W_DEF  = 19;
    localparam int OUT_W_DEF = 10;
    localparam int PCNT_W    = 20;

    localparam logic [18:0] LFSR_TAPS = 19'h00013;
    localparam logic [9:0]  MISR_TAPS = 10'h009;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } bist_state_t;

    // Bit 18 is the shifted-out bit; it always feeds back alongside the tap bits.
    function automatic logic [18:0] lfsr_next(input logic [18:0] p);
        return {p[17:0], p[18] ^ (^(p & LFSR_TAPS))};
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Bundle between the test front-end, the BIST controller and one gate-model instance.
// The controller uses the slave view; the front-end/model side uses the master view.
interface gate_bist_ctrl_if
    import gate_bist_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [PCNT_W-1:0] pat_count;
    logic [OUT_W-1:0]  golden;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [OUT_W-1:0]  signature;

    modport master (
        output start, abort, mode, pat_count, golden, dut_out,
        input  dut_in, busy, done, pass, signature
    );

    modport slave (
        input  start, abort, mode, pat_count, golden, dut_out,
        output dut_in, busy, done, pass, signature
    );

endinterface

// File: rtl/gate_bist_ctrl_misr.sv
// Multiple-input signature register: Galois-style shift with feedback taps,
// response word XORed in on every enabled cycle, synchronous reload to the seed.
module bist_misr #(
    parameter int             W    = 10,
    parameter logic [W-1:0]   TAPS = W'(9),
    parameter logic [W-1:0]   SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sig
);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_fb;

    assign w_fb  = r_sig[W-1] ? TAPS : '0;
    assign o_sig = r_sig;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= {r_sig[W-2:0], 1'b0} ^ w_fb ^ i_data;
        end
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: drives patterns (binary count or LFSR) into a gate model,
// waits SETTLE_CYC cycles per pattern, and compacts the responses into a MISR.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int                IN_W       = IN_W_DEF,
    parameter int                OUT_W      = OUT_W_DEF,
    parameter int                SETTLE_CYC = 2,
    parameter logic [IN_W-1:0]   LFSR_SEED  = IN_W'(1),
    parameter logic [OUT_W-1:0]  MISR_SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    gate_bist_ctrl_if.slave  bus
);

    localparam int CW = $clog2(SETTLE_CYC + 1) + 1;

    bist_state_t       r_state;
    bist_state_t       w_state_nxt;
    logic [IN_W-1:0]   r_pat;
    logic [IN_W-1:0]   r_dut_in;
    logic [IN_W-1:0]   w_pat_nxt;
    logic [PCNT_W-1:0] r_remain;
    logic [OUT_W-1:0]  r_golden;
    logic [CW-1:0]     r_settle_cnt;
    logic              r_mode;
    logic              r_done;
    logic              r_pass;
    logic              w_busy;
    logic              w_accept;
    logic              w_capture;
    logic              w_settle_last;
    logic [OUT_W-1:0]  w_sig;

    assign w_pat_nxt     = r_mode ? IN_W'(lfsr_next(19'(r_pat))) : r_pat + IN_W'(1);
    assign w_settle_last = (int'(r_settle_cnt) + 1 >= SETTLE_CYC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort out-ranks everything; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    w_state_nxt = (bus.pat_count == '0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settle_last) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = (r_remain == PCNT_W'(1)) ? ST_DONE : ST_APPLY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_accept  = bus.start && !bus.abort;
            ST_APPLY, ST_SETTLE: w_busy = 1'b1;
            ST_CAPTURE: begin
                w_busy    = 1'b1;
                w_capture = !bus.abort;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat        <= '0;
            r_dut_in     <= '0;
            r_remain     <= '0;
            r_golden     <= '0;
            r_settle_cnt <= '0;
            r_mode       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            if (w_busy && bus.abort) begin
                r_dut_in <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_accept) begin
                            r_remain <= bus.pat_count;
                            r_golden <= bus.golden;
                            r_mode   <= bus.mode;
                            r_pat    <= bus.mode ? LFSR_SEED : '0;
                        end
                    end
                    ST_APPLY: begin
                        r_dut_in     <= r_pat;
                        r_settle_cnt <= '0;
                    end
                    ST_SETTLE:  r_settle_cnt <= r_settle_cnt + CW'(1);
                    ST_CAPTURE: begin
                        r_pat    <= w_pat_nxt;
                        r_remain <= r_remain - PCNT_W'(1);
                    end
                    default: r_settle_cnt <= '0;
                endcase
            end
            // Registered one cycle after DONE is entered; drops on the edge that leaves DONE.
            r_done <= (r_state == ST_DONE) && !w_accept && !bus.abort;
            r_pass <= (r_state == ST_DONE) && !w_accept && !bus.abort && (w_sig == r_golden);
        end
    end

    bist_misr #(
        .W    (OUT_W),
        .TAPS (OUT_W'(MISR_TAPS)),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_en   (w_capture),
        .i_data (bus.dut_out),
        .o_sig  (w_sig)
    );

    assign bus.dut_in    = r_dut_in;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.signature = w_sig;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: timeline-based reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_gate_bist_ctrl;

    localparam int S = 2;
    localparam int P = S + 2;

    logic clk;
    logic rst;
    bit   rnd_out;
    int   n_checks;
    int   n_fail;

    gate_bist_ctrl_if #(.IN_W(19), .OUT_W(10)) bus ();

    gate_bist_ctrl #(
        .IN_W       (19),
        .OUT_W      (10),
        .SETTLE_CYC (S),
        .LFSR_SEED  (19'h00001),
        .MISR_SEED  (10'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [18:0] pat_adv(logic [18:0] p, bit m);
        if (m) return {p[17:0], p[18] ^ p[4] ^ p[1] ^ p[0]};
        return p + 19'd1;
    endfunction

    function automatic logic [9:0] misr_step(logic [9:0] s, logic [9:0] d);
        logic [9:0] n;
        for (int i = 1; i < 10; i++) n[i] = s[i-1] ^ d[i];
        n[0] = s[9] ^ d[0];
        n[3] = s[2] ^ s[9] ^ d[3];
        return n;
    endfunction

    // Reference model: a run started at edge mt with mN patterns has apply edges
    // at mt+k*P+1, capture edges at mt+(k+1)*P, and done from mt+mN*P+1.
    int         ec, mt, mN, md;
    bit         mph, m_mode, busy_b, done_b, cmp_en;
    logic [18:0] m_pat, e_dut_in;
    logic [9:0]  e_sig, m_gold;
    bit          e_busy, e_done, e_pass;

    always @(posedge clk) begin
        ec++;
        if (rst) begin
            mph      = 1'b0;
            e_dut_in = '0;
            e_sig    = 10'h000;
        end else begin
            md     = ec - mt;
            busy_b = mph && (md >= 1) && (md <= mN * P);
            done_b = mph && (md > mN * P);
            if (bus.abort) begin
                if (busy_b) begin
                    mph      = 1'b0;
                    e_dut_in = '0;
                end else if (done_b) begin
                    mph = 1'b0;
                end
            end else if (busy_b) begin
                if ((md - 1) % P == 0) e_dut_in = m_pat;
                if (md % P == 0) begin
                    e_sig = misr_step(e_sig, bus.dut_out);
                    m_pat = pat_adv(m_pat, m_mode);
                end
            end else if (bus.start && (!mph || done_b)) begin
                mph    = 1'b1;
                mt     = ec;
                mN     = int'(bus.pat_count);
                m_gold = bus.golden;
                m_mode = bus.mode;
                m_pat  = bus.mode ? 19'h00001 : 19'h00000;
                e_sig  = 10'h000;
            end
        end
        if (mph) begin
            md     = ec - mt;
            e_busy = (md < mN * P);
            e_done = (md >= mN * P + 1);
        end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
        end
        e_pass = e_done && (e_sig == m_gold);
        cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("dut_in", 32'(bus.dut_in), 32'(e_dut_in));
            chk("signature", 32'(bus.signature), 32'(e_sig));
            if (e_done) chk("pass", 32'(bus.pass), 32'(e_pass));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_out) bus.dut_out = 10'($urandom);
    endtask

    task automatic start_run(bit m, int n, logic [9:0] g);
        bus.mode      = m;
        bus.pat_count = 20'(n);
        bus.golden    = g;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rnd_out = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
        bus.pat_count = '0; bus.golden = '0; bus.dut_out = '0;
        step(); step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_dut_in", 32'(bus.dut_in), 0);
        chk("rst_sig", 32'(bus.signature), 0);
        rst = 1'b0;

        // Zero-length run
        start_run(1'b0, 0, 10'h000);
        chk("n0_done_early", 32'(bus.done), 0);
        step();
        chk("n0_done", 32'(bus.done), 1);
        chk("n0_sig", 32'(bus.signature), 10'h000);
        chk("n0_pass", 32'(bus.pass), 1);

        // Counting patterns with a quiet response
        bus.dut_out = 10'h000;
        start_run(1'b0, 4, 10'h000);
        for (int d = 1; d <= 4 * P + 1; d++) begin
            step();
            if (d == 1)         chk("cnt_in0", 32'(bus.dut_in), 0);
            if (d == P + 1)     chk("cnt_in1", 32'(bus.dut_in), 1);
            if (d == 2 * P + 1) chk("cnt_in2", 32'(bus.dut_in), 2);
            if (d == 3 * P + 1) chk("cnt_in3", 32'(bus.dut_in), 3);
            if (d == 4 * P)     chk("cnt_done_early", 32'(bus.done), 0);
        end
        chk("cnt_done", 32'(bus.done), 1);
        chk("cnt_sig", 32'(bus.signature), 10'h000);

        // Constant response 001: signature 001 then 003
        bus.dut_out = 10'h001;
        start_run(1'b0, 2, 10'h003);
        repeat (P) step();
        chk("misr_sig1", 32'(bus.signature), 10'h001);
        chk("model_sig1", 32'(e_sig), 10'h001);
        repeat (P) step();
        chk("misr_sig2", 32'(bus.signature), 10'h003);
        step();
        chk("misr_done", 32'(bus.done), 1);
        chk("misr_pass", 32'(bus.pass), 1);
        start_run(1'b0, 2, 10'h002);
        repeat (2 * P + 1) step();
        chk("misr_done_b", 32'(bus.done), 1);
        chk("misr_sig_b", 32'(bus.signature), 10'h003);
        chk("misr_nopass", 32'(bus.pass), 0);

        // LFSR pattern sequence
        rnd_out = 1'b1;
        start_run(1'b1, 3, 10'h000);
        step();
        chk("lfsr_in0", 32'(bus.dut_in), 19'h00001);
        repeat (P) step();
        chk("lfsr_in1", 32'(bus.dut_in), 19'h00003);
        repeat (P) step();
        chk("lfsr_in2", 32'(bus.dut_in), 19'h00006);
        chk("model_lfsr2", 32'(e_dut_in), 19'h00006);
        repeat (P) step();
        chk("lfsr_done", 32'(bus.done), 1);

        // Abort during the settle of the second pattern
        rnd_out = 1'b0;
        bus.dut_out = 10'h001;
        start_run(1'b0, 4, 10'h000);
        repeat (P + 1) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_dut_in", 32'(bus.dut_in), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_sig", 32'(bus.signature), 10'h001);
        repeat (10) step();
        chk("abort_done_late", 32'(bus.done), 0);
        start_run(1'b1, 2, 10'h000);
        step();
        chk("restart_in0", 32'(bus.dut_in), 19'h00001);
        repeat (2 * P) step();
        chk("restart_done", 32'(bus.done), 1);

        // Start while busy is ignored; reset during CAPTURE
        rnd_out = 1'b1;
        start_run(1'b0, 3, 10'h000);
        step(); step();
        bus.start = 1'b1; bus.mode = 1'b1; bus.pat_count = 20'd1;
        step();
        bus.start = 1'b0;
        repeat (P - 2) step();
        chk("busy_start_in1", 32'(bus.dut_in), 1);
        repeat (2 * P) step();
        chk("busy_start_done", 32'(bus.done), 1);
        start_run(1'b0, 3, 10'h000);
        repeat (2 * P - 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_pass", 32'(bus.pass), 0);
        chk("midrst_dut_in", 32'(bus.dut_in), 0);
        chk("midrst_sig", 32'(bus.signature), 10'h000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.start     = ($urandom_range(0, 9) == 0);
            bus.abort     = ($urandom_range(0, 59) == 0);
            rst           = ($urandom_range(0, 799) == 0);
            bus.mode      = 1'($urandom);
            bus.pat_count = 20'($urandom_range(0, 5));
            bus.golden    = 10'($urandom_range(0, 3));
            step();
        end
        bus.start = 1'b0; bus.abort = 1'b0; rst = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
